// File: rtl/pi_eye_sweep_ctrl.sv
// rtl/pi_eye_sweep_ctrl.sv - PI phase sweep controller that finds and centres the widest passing eye window
module pi_eye_sweep_ctrl #(
  parameter int STEP_W     = 4,
  parameter int NUM_STEPS  = 16,
  parameter int SETTLE_CYC = 8,
  parameter int SAMPLE_CYC = 16,
  parameter int ERR_THRESH = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_cmp_valid,
  input  logic              i_cmp_err,
  output logic [STEP_W-1:0] o_step_sel,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [STEP_W-1:0] o_eye_left,
  output logic [STEP_W-1:0] o_eye_right,
  output logic [STEP_W:0]   o_eye_width,
  output logic [STEP_W-1:0] o_center
);

  // Error/sample counters share one width; the error counter saturates at all-ones.
  localparam int CNT_W = $clog2(SAMPLE_CYC) + 1;
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [CNT_W-1:0]  ERR_MAX     = {CNT_W{1'b1}};
  localparam logic [STEP_W-1:0] LAST_CODE   = STEP_W'(NUM_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_FINAL
  } state_t;

  state_t            state;
  logic [SET_W-1:0]  settle_cnt;
  logic [CNT_W-1:0]  samp_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic [STEP_W:0]   run_len;
  logic [STEP_W-1:0] run_start;
  logic [STEP_W:0]   best_len;
  logic [STEP_W-1:0] best_start;

  logic              code_pass;
  logic [STEP_W:0]   fin_len;
  logic [STEP_W-1:0] fin_start;
  logic [STEP_W-1:0] fin_last_off;
  logic [STEP_W-1:0] fin_right;
  logic [STEP_W-1:0] fin_center;

  // Pass/fail of the current code from its accumulated error count.
  always_comb begin
    code_pass = 32'(err_cnt) <= ERR_THRESH;
  end

  // Final window: an open run at sweep end competes with the best closed run (strictly longer wins).
  always_comb begin
    fin_len   = best_len;
    fin_start = best_start;
    if (run_len > best_len) begin
      fin_len   = run_len;
      fin_start = run_start;
    end
    // width-1 taken modulo 2**STEP_W so a full-range window (width = NUM_STEPS) still maps correctly
    fin_last_off = fin_len[STEP_W-1:0] - STEP_W'(1);
    fin_right    = fin_start + fin_last_off;
    fin_center   = fin_start + (fin_last_off >> 1);
    if (fin_len == '0) begin
      fin_start  = '0;
      fin_right  = '0;
      fin_center = '0;
    end
  end

  // Sweep FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      settle_cnt  <= '0;
      samp_cnt    <= '0;
      err_cnt     <= '0;
      run_len     <= '0;
      run_start   <= '0;
      best_len    <= '0;
      best_start  <= '0;
      o_step_sel  <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_eye_left  <= '0;
      o_eye_right <= '0;
      o_eye_width <= '0;
      o_center    <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state       <= S_SETTLE;
            settle_cnt  <= '0;
            samp_cnt    <= '0;
            err_cnt     <= '0;
            run_len     <= '0;
            run_start   <= '0;
            best_len    <= '0;
            best_start  <= '0;
            o_step_sel  <= '0;
            o_busy      <= 1'b1;
            o_pass      <= 1'b0;
            o_eye_left  <= '0;
            o_eye_right <= '0;
            o_eye_width <= '0;
            o_center    <= '0;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          if (i_cmp_valid) begin
            if (i_cmp_err && (err_cnt != ERR_MAX)) begin
              err_cnt <= err_cnt + 1'b1;
            end
            if (samp_cnt == SAMPLE_LAST) begin
              samp_cnt <= '0;
              state    <= S_EVAL;
            end else begin
              samp_cnt <= samp_cnt + 1'b1;
            end
          end
        end
        S_EVAL: begin
          if (code_pass) begin
            if (run_len == '0) begin
              run_start <= o_step_sel;
            end
            run_len <= run_len + 1'b1;
          end else begin
            if (run_len > best_len) begin
              best_len   <= run_len;
              best_start <= run_start;
            end
            run_len <= '0;
          end
          err_cnt  <= '0;
          samp_cnt <= '0;
          if (o_step_sel == LAST_CODE) begin
            state <= S_FINAL;
          end else begin
            o_step_sel <= o_step_sel + 1'b1;
            state      <= S_SETTLE;
          end
        end
        S_FINAL: begin
          o_eye_left  <= fin_start;
          o_eye_right <= fin_right;
          o_eye_width <= fin_len;
          o_center    <= fin_center;
          o_pass      <= (fin_len != '0);
          o_step_sel  <= (fin_len != '0) ? fin_center : '0;
          o_done      <= 1'b1;
          o_busy      <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
